// File: rtl/pc_unit_if.sv
// Bundle of control inputs and PC/trap status outputs between the control unit
// and the program-counter unit.
interface pc_unit_if #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4,
    parameter int CNT_W   = 32
);
    logic               en_i;
    logic               redirect_i;
    logic [XLEN-1:0]    redirect_target_i;
    logic               trap_i;
    logic [CAUSE_W-1:0] trap_cause_i;
    logic               mret_i;
    logic               finish_flag;
    logic               resume_i;
    logic [XLEN-1:0]    pc_o;
    logic [XLEN-1:0]    pc_next_o;
    logic [XLEN-1:0]    epc_o;
    logic [CAUSE_W-1:0] cause_o;
    logic [1:0]         state_o;
    logic               halted_o;
    logic               misalign_o;
    logic [CNT_W-1:0]   retire_cnt_o;

    modport master (
        output en_i, redirect_i, redirect_target_i, trap_i, trap_cause_i,
               mret_i, finish_flag, resume_i,
        input  pc_o, pc_next_o, epc_o, cause_o, state_o, halted_o,
               misalign_o, retire_cnt_o
    );

    modport slave (
        input  en_i, redirect_i, redirect_target_i, trap_i, trap_cause_i,
               mret_i, finish_flag, resume_i,
        output pc_o, pc_next_o, epc_o, cause_o, state_o, halted_o,
               misalign_o, retire_cnt_o
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: PC register with increment/redirect, trap entry and
// return, halt/resume control and a saturating retired-instruction counter.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'hFFFF_FFFC,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              CNT_W        = 32,
    parameter int              CAUSE_W      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    pc_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TRAP = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               misalign_q, misalign_d;
    logic               halted_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               advance;
    logic               misTarget;

    assign misTarget = |(bus.redirect_target_i & ALIGN_MASK);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        misalign_d = 1'b0;
        advance    = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            RUN, TRAP: begin
                if (bus.finish_flag) begin
                    state_d = HALT;
                end else if (state_q == RUN && bus.trap_i) begin
                    epc_d   = pc_q;
                    cause_d = bus.trap_cause_i;
                    pc_d    = TRAP_VECTOR;
                    state_d = TRAP;
                end else if (state_q == TRAP && bus.en_i && bus.mret_i) begin
                    pc_d    = epc_q;
                    state_d = RUN;
                    advance = 1'b1;
                end else if (bus.en_i && bus.redirect_i && misTarget) begin
                    // In TRAP a bad target only pulses the flag; no nested trap.
                    misalign_d = 1'b1;
                    if (state_q == RUN) begin
                        epc_d   = pc_q;
                        cause_d = '0;
                        pc_d    = TRAP_VECTOR;
                        state_d = TRAP;
                    end
                end else if (bus.en_i && bus.redirect_i) begin
                    pc_d    = bus.redirect_target_i;
                    advance = 1'b1;
                end else if (bus.en_i) begin
                    pc_d    = pc_q + XLEN'(INC);
                    advance = 1'b1;
                end
            end
            HALT: begin
                if (bus.resume_i && !bus.finish_flag) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (advance && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            cause_q    <= '0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            misalign_q <= misalign_d;
            halted_q   <= (state_d == HALT);
            cnt_q      <= cnt_d;
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.pc_next_o    = pc_d;
    assign bus.epc_o        = epc_q;
    assign bus.cause_o      = cause_q;
    assign bus.state_o      = state_q;
    assign bus.halted_o     = halted_q;
    assign bus.misalign_o   = misalign_q;
    assign bus.retire_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_pc_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    bit   cmpOn = 1'b0;

    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32), .CAUSE_W(4), .CNT_W(32)) bus ();
    pc_unit_if #(.XLEN(32), .CAUSE_W(4), .CNT_W(3))  busS ();

    pc_unit #(.CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    pc_unit #(.CNT_W(3))  dutS (.clk(clk), .reset_n(reset_n), .bus(busS));

    assign busS.en_i              = bus.en_i;
    assign busS.redirect_i        = bus.redirect_i;
    assign busS.redirect_target_i = bus.redirect_target_i;
    assign busS.trap_i            = bus.trap_i;
    assign busS.trap_cause_i      = bus.trap_cause_i;
    assign busS.mret_i            = bus.mret_i;
    assign busS.finish_flag       = bus.finish_flag;
    assign busS.resume_i          = bus.resume_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [3:0]  cause;
        int          st;
        bit          mis;
        longint      cnt;
        longint      cnt3;
    } mdl_t;

    mdl_t mdl = '{pc: 32'hFFFF_FFFC, epc: 0, cause: 0, st: 0, mis: 0, cnt: 0, cnt3: 0};

    function automatic mdl_t resetModel();
        mdl_t r;
        r.pc = 32'hFFFF_FFFC; r.epc = 0; r.cause = 0; r.st = 0;
        r.mis = 0; r.cnt = 0; r.cnt3 = 0;
        return r;
    endfunction

    // Next architectural state from the current one and the inputs on the bus.
    function automatic mdl_t stepModel(mdl_t m);
        mdl_t n = m;
        bit adv = 0;
        n.mis = 0;
        if (m.st == 2) begin
            if (bus.resume_i && !bus.finish_flag) n.st = 0;
        end else if (bus.finish_flag) begin
            n.st = 2;
        end else if (m.st == 0 && bus.trap_i) begin
            n.epc = m.pc; n.cause = bus.trap_cause_i; n.pc = 32'h100; n.st = 1;
        end else if (m.st == 1 && bus.en_i && bus.mret_i) begin
            n.pc = m.epc; n.st = 0; adv = 1;
        end else if (bus.en_i && bus.redirect_i && (bus.redirect_target_i % 4) != 0) begin
            n.mis = 1;
            if (m.st == 0) begin
                n.epc = m.pc; n.cause = 0; n.pc = 32'h100; n.st = 1;
            end
        end else if (bus.en_i && bus.redirect_i) begin
            n.pc = bus.redirect_target_i; adv = 1;
        end else if (bus.en_i) begin
            n.pc = m.pc + 32'd4; adv = 1;
        end
        if (adv) begin
            n.cnt  = (m.cnt  + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m.cnt + 1;
            n.cnt3 = (m.cnt3 + 1 > 7) ? 7 : m.cnt3 + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) mdl = resetModel();
        else          mdl = stepModel(mdl);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmpOn && reset_n) begin
            mdl_t nx;
            nx = stepModel(mdl);
            checkOutput("m_pc_next", bus.pc_next_o, nx.pc);
            checkOutput("m_pc", bus.pc_o, mdl.pc);
            checkOutput("m_epc", bus.epc_o, mdl.epc);
            checkOutput("m_cause", 32'(bus.cause_o), 32'(mdl.cause));
            checkOutput("m_state", 32'(bus.state_o), 32'(mdl.st));
            checkOutput("m_halted", 32'(bus.halted_o), 32'(mdl.st == 2));
            checkOutput("m_misalign", 32'(bus.misalign_o), 32'(mdl.mis));
            checkOutput("m_cnt", bus.retire_cnt_o, mdl.cnt[31:0]);
            checkOutput("m_cnt3", 32'(busS.retire_cnt_o), mdl.cnt3[31:0]);
        end
    end

    task automatic applyStimulus(input bit en, input bit redir, input logic [31:0] tgt,
                                 input bit trap, input logic [3:0] cause, input bit mret,
                                 input bit fin, input bit res);
        bus.en_i = en; bus.redirect_i = redir; bus.redirect_target_i = tgt;
        bus.trap_i = trap; bus.trap_cause_i = cause; bus.mret_i = mret;
        bus.finish_flag = fin; bus.resume_i = res;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en_i = 0; bus.redirect_i = 0; bus.redirect_target_i = 0; bus.trap_i = 0;
        bus.trap_cause_i = 0; bus.mret_i = 0; bus.finish_flag = 0; bus.resume_i = 0;
        #23;
        checkOutput("rst_pc", bus.pc_o, 32'hFFFF_FFFC);
        checkOutput("rst_state", 32'(bus.state_o), 32'd0);
        checkOutput("rst_cnt", bus.retire_cnt_o, 32'd0);
        checkOutput("rst_halted", 32'(bus.halted_o), 32'd0);
        reset_n = 1'b1;
        cmpOn = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap_pc0", bus.pc_o, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("inc_pc4", bus.pc_o, 32'h4);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("inc_pc8", bus.pc_o, 32'h8);
        checkOutput("cnt3", bus.retire_cnt_o, 32'd3);
        checkOutput("model_pc8", mdl.pc, 32'h8);

        applyStimulus(1, 1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("redir_pc", bus.pc_o, 32'h40);
        checkOutput("redir_cnt", bus.retire_cnt_o, 32'd4);
        applyStimulus(1, 1, 32'h42, 0, 0, 0, 0, 0);
        checkOutput("mis_pulse", 32'(bus.misalign_o), 32'd1);
        checkOutput("mis_pc", bus.pc_o, 32'h100);
        checkOutput("mis_epc", bus.epc_o, 32'h40);
        checkOutput("mis_cause", 32'(bus.cause_o), 32'd0);
        checkOutput("mis_state", 32'(bus.state_o), 32'd1);
        checkOutput("mis_cnt", bus.retire_cnt_o, 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mis_clear", 32'(bus.misalign_o), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("mret_pc", bus.pc_o, 32'h40);
        checkOutput("mret_state", 32'(bus.state_o), 32'd0);

        applyStimulus(1, 1, 32'h10, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'hB, 0, 0, 0);
        checkOutput("trap_pc", bus.pc_o, 32'h100);
        checkOutput("trap_epc", bus.epc_o, 32'h10);
        checkOutput("trap_cause", 32'(bus.cause_o), 32'hB);
        applyStimulus(0, 0, 0, 1, 4'h3, 0, 0, 0);
        checkOutput("nest_pc", bus.pc_o, 32'h100);
        checkOutput("nest_cause", 32'(bus.cause_o), 32'hB);
        applyStimulus(1, 1, 32'h202, 0, 0, 0, 0, 0);
        checkOutput("trapmis_pc", bus.pc_o, 32'h104 - 32'h4);
        checkOutput("trapmis_pulse", 32'(bus.misalign_o), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("mret2_pc", bus.pc_o, 32'h10);
        checkOutput("mret2_state", 32'(bus.state_o), 32'd0);
        checkOutput("mret2_cnt", bus.retire_cnt_o, 32'd7);

        applyStimulus(1, 1, 32'h20, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 4'h6, 0, 1, 0);
        checkOutput("halt_state", 32'(bus.state_o), 32'd2);
        checkOutput("halt_pc", bus.pc_o, 32'h20);
        checkOutput("halt_flag", 32'(bus.halted_o), 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 32'h80, 1, 4'h2, 1, 0, 0);
        checkOutput("halt_hold_pc", bus.pc_o, 32'h20);
        checkOutput("halt_hold_epc", bus.epc_o, 32'h10);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("halt_both", 32'(bus.state_o), 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("resume_state", 32'(bus.state_o), 32'd0);
        checkOutput("resume_halted", 32'(bus.halted_o), 32'd0);
        checkOutput("resume_pc", bus.pc_o, 32'h20);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resume_inc", bus.pc_o, 32'h24);
        checkOutput("cnt9", bus.retire_cnt_o, 32'd9);
        checkOutput("sat_cnt3", 32'(busS.retire_cnt_o), 32'd7);

        applyStimulus(0, 0, 0, 1, 4'h5, 0, 0, 0);
        checkOutput("pre_rst_state", 32'(bus.state_o), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_pc", bus.pc_o, 32'hFFFF_FFFC);
        checkOutput("async_state", 32'(bus.state_o), 32'd0);
        checkOutput("async_epc", bus.epc_o, 32'd0);
        checkOutput("async_cause", 32'(bus.cause_o), 32'd0);
        checkOutput("async_cnt", bus.retire_cnt_o, 32'd0);
        checkOutput("async_cnt3", 32'(busS.retire_cnt_o), 32'd0);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t = t & 32'hFFFF_FFFC;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, t,
                          $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) == 0);
        end

        cmpOn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle RISC-V core.
- Owns the PC register, sequential increment, and branch/jump redirect.
- Adds trap entry/return with saved EPC and cause, misaligned-target detection, a halt/resume state machine, and a saturating retired-instruction counter.
- Feeds instruction memory and branch logic; the control unit drives the redirect, trap, finish and resume inputs.

Parameters:
XLEN, 32, PC and address width
RESET_VECTOR, 32'hFFFF_FFFC, PC value on reset (-4, so the first increment fetches address 0)
TRAP_VECTOR, 32'h0000_0100, handler entry address
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero
CNT_W, 32, retired-counter width
CAUSE_W, 4, trap-cause width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
en_i  input  1  advance enable; 0 = stall
redirect_i  input  1  taken branch/jump
redirect_target_i  input  XLEN  redirect destination
trap_i  input  1  exception request
trap_cause_i  input  CAUSE_W  cause code for trap_i
mret_i  input  1  return from handler
finish_flag  input  1  halt request
resume_i  input  1  leave HALT
pc_o  output  XLEN  current PC (registered)
pc_next_o  output  XLEN  combinational value pc_o takes at the next edge
epc_o  output  XLEN  saved trap PC
cause_o  output  CAUSE_W  saved trap cause
state_o  output  2  RUN=0, TRAP=1, HALT=2
halted_o  output  1  1 while in HALT
misalign_o  output  1  one-cycle pulse on a misaligned redirect
retire_cnt_o  output  CNT_W  count of PC advances

Behaviour:
- Reset (reset_n=0): takes effect immediately, regardless of clock.
  - pc_o=RESET_VECTOR, state=RUN, epc_o=0, cause_o=0, misalign_o=0, retire_cnt_o=0, halted_o=0.
  - Reset asserted mid-operation, including in TRAP or HALT, gives the same result.
- All other updates occur on the rising edge of clk.
- RUN, evaluated in priority order each cycle:
  1. finish_flag=1: PC holds; next state HALT.
  2. trap_i=1 (en_i ignored): epc<=pc_o, cause<=trap_cause_i, pc<=TRAP_VECTOR; next state TRAP.
  3. en_i & redirect_i & target[ALIGN_BITS-1:0]!=0: misalign_o=1 for one cycle; acts as trap with cause 0 (epc<=pc_o, pc<=TRAP_VECTOR, state TRAP).
  4. en_i & redirect_i, aligned target: pc<=redirect_target_i.
  5. en_i: pc<=pc_o+INC, modulo 2^XLEN (RESET_VECTOR+INC wraps to 0).
  6. Otherwise PC holds.
- TRAP:
  - Same rules as RUN, except trap_i and misaligned redirects are ignored (no nesting); epc/cause stay unchanged.
  - Misaligned redirect in TRAP: PC holds, misalign_o still pulses.
  - en_i & mret_i (priority after finish_flag, before redirect): pc<=epc_o; next state RUN.
- HALT:
  - PC, epc and cause hold; halted_o=1; en_i, redirect_i, trap_i and mret_i are ignored.
  - resume_i=1 & finish_flag=0: next state RUN with PC unchanged.
  - resume_i and finish_flag together: stay in HALT.
- mret_i in RUN is ignored.
- retire_cnt_o increments by 1 on every sequential or aligned-redirect update, including mret.
  - Does not increment on trap entry, hold, or in HALT.
  - Saturates at 2^CNT_W-1.
- pc_next_o equals the value the register will load at the next edge under current inputs; equals pc_o when holding. No other combinational paths to outputs.
- Latency: one cycle from input to pc_o.

Test Plan:
- Release reset, en_i=1 for 3 cycles -> pc_o: FFFFFFFC, 0, 4, 8; retire_cnt_o=3.
- At pc=8: redirect_i=1, target=0x40 -> pc_o=0x40, count+1. Same with target=0x42 -> misalign_o pulse, pc_o=0x100, epc_o=0x40, cause_o=0, state_o=TRAP.
- At pc=0x10, trap_i=1, cause=0xB, en_i=0 -> pc_o=0x100, epc_o=0x10, cause_o=0xB. Then trap_i=1 again in TRAP -> ignored. Then en_i=1, mret_i=1 -> pc_o=0x10, state RUN.
- finish_flag=1 together with trap_i=1 at pc=0x20 -> HALT, pc stays 0x20, halted_o=1. en_i/redirect_i ignored for 5 cycles. resume_i=1 -> RUN; next en_i -> 0x24.
- Assert reset_n=0 between clock edges while in TRAP -> outputs reach reset values immediately; count=0.
- CNT_W=3, 10 advances -> retire_cnt_o saturates at 7. XLEN=32, pc=FFFFFFFC, en_i=1 -> wraps to 0.
